fir_seq_accum: RTL and testbench



---
 rtl/fir_seq_accum.sv | 132 +++++++++++++
 tb/tb_fir_seq_accum.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_seq_accum.sv
// Sequential dual-channel FIR MAC: walks the coefficient ROM in step with a queue burst, emits one scaled L/R pair per burst.
// Optional output clamping is enabled by defining FIR_SAT_EN; otherwise the output slice wraps.
module fir_seq_accum #(
    parameter int N_TAPS = 1021,
    parameter int ADDR_W = 10,
    parameter int ACC_W  = 40,
    parameter int SHIFT  = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sequencing,
    input  logic signed [15:0]       lft_smpl,
    input  logic signed [15:0]       rght_smpl,
    output logic        [ADDR_W-1:0] coeff_addr,
    input  logic signed [15:0]       coeff,
    output logic        [15:0]       lft_out,
    output logic        [15:0]       rght_out,
    output logic                     vld,
    output logic                     frm_err,
    output logic                     busy
);

    // Burst-length counter saturates one past N_TAPS so short/exact/long stay distinguishable.
    localparam int CW = $clog2(N_TAPS + 2);
    localparam logic [CW-1:0]     CNT_FULL  = CW'(N_TAPS);
    localparam logic [CW-1:0]     CNT_OVER  = CW'(N_TAPS + 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(N_TAPS - 1);
    localparam logic [ADDR_W-1:0] ADDR_2ND  = (N_TAPS > 1) ? ADDR_W'(1) : '0;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_DONE} state_t;

    state_t                    r_state;
    logic                      r_seq_d;
    logic                      r_drn;
    logic [CW-1:0]             r_cnt;
    logic [1:0]                r_vld_pipe;
    logic signed [31:0]        r_prod_l;
    logic signed [31:0]        r_prod_r;
    logic signed [ACC_W-1:0]   r_acc_l;
    logic signed [ACC_W-1:0]   r_acc_r;

    logic                      w_rise;
    logic                      w_issue;
    logic [15:0]               w_out_l;
    logic [15:0]               w_out_r;

    assign w_rise  = sequencing & ~r_seq_d;
    // A tap is issued on the accepted rise and on every following sequencing cycle, up to N_TAPS.
    assign w_issue = sequencing && (r_cnt < CNT_FULL) &&
                     ((r_state == S_ACCUM) || (r_state == S_IDLE && !r_seq_d));
    assign busy    = (r_state != S_IDLE);

    always_comb begin
        w_out_l = r_acc_l[SHIFT+15:SHIFT];
        w_out_r = r_acc_r[SHIFT+15:SHIFT];
`ifdef FIR_SAT_EN
        if (!(&r_acc_l[ACC_W-1:SHIFT+15]) && (|r_acc_l[ACC_W-1:SHIFT+15]))
            w_out_l = r_acc_l[ACC_W-1] ? 16'h8000 : 16'h7FFF;
        if (!(&r_acc_r[ACC_W-1:SHIFT+15]) && (|r_acc_r[ACC_W-1:SHIFT+15]))
            w_out_r = r_acc_r[ACC_W-1] ? 16'h8000 : 16'h7FFF;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_seq_d    <= 1'b0;
            r_drn      <= 1'b0;
            r_cnt      <= '0;
            r_vld_pipe <= '0;
            r_prod_l   <= '0;
            r_prod_r   <= '0;
            r_acc_l    <= '0;
            r_acc_r    <= '0;
            coeff_addr <= '0;
            lft_out    <= '0;
            rght_out   <= '0;
            vld        <= 1'b0;
            frm_err    <= 1'b0;
        end else begin
            r_seq_d    <= sequencing;
            r_vld_pipe <= {r_vld_pipe[0], w_issue};
            r_prod_l   <= 32'(lft_smpl) * 32'(coeff);
            r_prod_r   <= 32'(rght_smpl) * 32'(coeff);
            if (r_vld_pipe[1]) begin
                r_acc_l <= r_acc_l + ACC_W'(r_prod_l);
                r_acc_r <= r_acc_r + ACC_W'(r_prod_r);
            end
            vld     <= 1'b0;
            frm_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_rise) begin
                        r_acc_l    <= '0;
                        r_acc_r    <= '0;
                        r_cnt      <= CW'(1);
                        coeff_addr <= ADDR_2ND;
                        r_state    <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (sequencing) begin
                        if (r_cnt != CNT_OVER)
                            r_cnt <= r_cnt + CW'(1);
                        if (coeff_addr != ADDR_LAST)
                            coeff_addr <= coeff_addr + ADDR_W'(1);
                    end else begin
                        r_drn   <= 1'b0;
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    r_drn <= 1'b1;
                    // Last product lands in the accumulator before the second drain cycle.
                    if (r_drn) begin
                        lft_out  <= w_out_l;
                        rght_out <= w_out_r;
                        vld      <= 1'b1;
                        frm_err  <= (r_cnt != CNT_FULL);
                        r_state  <= S_DONE;
                    end
                end
                default: begin
                    r_cnt      <= '0;
                    coeff_addr <= '0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_seq_accum.sv
// Self-checking bench for fir_seq_accum (N_TAPS=8): directed test-plan bursts plus random bursts vs. a sum-of-products model.
module tb_fir_seq_accum;
    localparam int N      = 8;
    localparam int ADDR_W = 3;
    localparam int ACC_W  = 40;
    localparam int SHIFT  = 15;

    logic               clk = 1'b0;
    logic               rst;
    logic               sequencing;
    logic signed [15:0] lft_smpl, rght_smpl, coeff;
    logic [ADDR_W-1:0]  coeff_addr;
    logic [15:0]        lft_out, rght_out;
    logic               vld, frm_err, busy;

    fir_seq_accum #(.N_TAPS(N), .ADDR_W(ADDR_W), .ACC_W(ACC_W), .SHIFT(SHIFT)) dut (
        .clk(clk), .rst(rst), .sequencing(sequencing),
        .lft_smpl(lft_smpl), .rght_smpl(rght_smpl),
        .coeff_addr(coeff_addr), .coeff(coeff),
        .lft_out(lft_out), .rght_out(rght_out),
        .vld(vld), .frm_err(frm_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic signed [15:0] rom [N];
    logic signed [15:0] sl [64];
    logic signed [15:0] sr [64];
    logic [ADDR_W-1:0]  addr_seen [64];

    logic              prev_seq = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;
    int                prev_k = 0;
    int                k = 0;
    int                cyc_n = 0;
    int                vld_cnt = 0;
    int                vld_cyc = 0;
    logic [15:0]       got_l = '0, got_r = '0;
    logic              got_fe = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // One clock: the queue/ROM return data for the previous cycle's request, then new controls are applied.
    task automatic cyc(input logic s, input logic r);
        @(posedge clk);
        #1;
        coeff = rom[prev_addr];
        if (prev_seq) begin
            lft_smpl  = sl[prev_k];
            rght_smpl = sr[prev_k];
        end else begin
            lft_smpl  = 16'($urandom);
            rght_smpl = 16'($urandom);
        end
        sequencing = s;
        rst        = r;
        cyc_n++;
        if (vld) begin
            vld_cnt++;
            vld_cyc = cyc_n;
            got_l   = lft_out;
            got_r   = rght_out;
            got_fe  = frm_err;
        end
        prev_addr = coeff_addr;
        prev_seq  = s;
        prev_k    = k;
        if (s) begin
            addr_seen[k] = coeff_addr;
            k++;
        end
    endtask

    function automatic logic [15:0] scale(input longint a);
        longint hi;
        hi = a >>> (SHIFT + 15);
`ifdef FIR_SAT_EN
        if (hi > 0)  return 16'h7FFF;
        if (hi < -1) return 16'h8000;
`endif
        return 16'((a >>> SHIFT) & 64'hFFFF);
    endfunction

    // Reference: dot product of the first min(len, N) samples with the ROM, then scaled.
    task automatic model(input int len, output logic [15:0] el, output logic [15:0] er);
        longint al = 0, ar = 0;
        int n;
        n = (len < N) ? len : N;
        for (int i = 0; i < n; i++) begin
            al += longint'(sl[i]) * longint'(rom[i]);
            ar += longint'(sr[i]) * longint'(rom[i]);
        end
        el = scale(al);
        er = scale(ar);
    endtask

    task automatic set_const(input logic [15:0] l, input logic [15:0] r, input logic [15:0] c);
        for (int i = 0; i < N; i++) rom[i] = c;
        for (int i = 0; i < 64; i++) begin
            sl[i] = l;
            sr[i] = r;
        end
    endtask

    task automatic set_rand();
        for (int i = 0; i < N; i++) rom[i] = 16'($urandom);
        for (int i = 0; i < 64; i++) begin
            sl[i] = 16'($urandom);
            sr[i] = 16'($urandom);
        end
    endtask

    task automatic burst(input int len, input string tag);
        int t0;
        logic [15:0] el, er;
        k = 0;
        vld_cnt = 0;
        t0 = cyc_n + 1;
        for (int i = 0; i < len; i++) cyc(1'b1, 1'b0);
        for (int i = 0; i < 12; i++) cyc(1'b0, 1'b0);
        model(len, el, er);
        chk({tag, "_nvld"}, vld_cnt, 1);
        chk({tag, "_vcyc"}, vld_cyc, t0 + len + 3);
        chk({tag, "_l"}, got_l, el);
        chk({tag, "_r"}, got_r, er);
        chk({tag, "_ferr"}, got_fe, (len != N) ? 1 : 0);
        chk({tag, "_hold"}, lft_out, el);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        int t0;
        rst = 1'b1;
        sequencing = 1'b0;
        lft_smpl = '0;
        rght_smpl = '0;
        coeff = '0;
        set_const(16'h0, 16'h0, 16'h0);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        chk("rst_vld", vld, 0);
        chk("rst_busy", busy, 0);
        chk("rst_lft", lft_out, 0);
        chk("rst_rght", rght_out, 0);
        chk("rst_addr", coeff_addr, 0);
        chk("rst_ferr", frm_err, 0);

        // Nominal burst
        set_const(16'h0100, 16'hFF00, 16'h4000);
        burst(8, "nom");
        chk("nom_l_const", got_l, 16'h0400);
        chk("nom_r_const", got_r, 16'hFC00);
        for (int i = 0; i < N; i++) chk($sformatf("nom_addr%0d", i), addr_seen[i], i);

        // Saturation cases
        set_const(16'h7FFF, 16'h7FFF, 16'h7FFF);
        burst(8, "psat");
`ifdef FIR_SAT_EN
        chk("psat_const", got_l, 16'h7FFF);
`else
        chk("psat_const", got_l, 16'hFFF0);
`endif
        set_const(16'h8000, 16'h8000, 16'h7FFF);
        burst(8, "nsat");
`ifdef FIR_SAT_EN
        chk("nsat_const", got_l, 16'h8000);
`else
        chk("nsat_const", got_l, 16'h0008);
`endif

        // Short and long bursts
        set_const(16'h0100, 16'hFF00, 16'h4000);
        burst(6, "short");
        chk("short_const", got_l, 16'h0300);
        burst(10, "long");
        chk("long_const", got_l, 16'h0400);
        chk("long_addr8", addr_seen[8], 7);
        chk("long_addr9", addr_seen[9], 7);

        // Reset on the 4th burst cycle
        set_rand();
        k = 0;
        vld_cnt = 0;
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b0);
        chk("mrst_lft", lft_out, 0);
        chk("mrst_rght", rght_out, 0);
        chk("mrst_vld", vld, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_addr", coeff_addr, 0);
        chk("mrst_ferr", frm_err, 0);
        for (int i = 0; i < 12; i++) cyc(1'b0, 1'b0);
        chk("mrst_novld", vld_cnt, 0);
        set_const(16'h0100, 16'hFF00, 16'h4000);
        burst(8, "mrst_nom");
        chk("mrst_nom_const", got_l, 16'h0400);

        // Second rise during DRAIN is ignored
        k = 0;
        vld_cnt = 0;
        t0 = cyc_n + 1;
        for (int i = 0; i < N; i++) cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        for (int i = 0; i < 12; i++) cyc(1'b0, 1'b0);
        chk("early_nvld", vld_cnt, 1);
        chk("early_vcyc", vld_cyc, t0 + N + 3);
        chk("early_l", got_l, 16'h0400);
        chk("early_ferr", got_fe, 0);
        chk("early_busy", busy, 0);
        set_rand();
        burst(8, "early_next");

        // Random bursts
        for (int r = 0; r < 12; r++) begin
            set_rand();
            burst($urandom_range(5, 11), $sformatf("rnd%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
